// File: rtl/audio_stream_ctrl.sv
// audio_stream_ctrl: pops one CODEC sample pair, runs it through the engine (or bypasses it), pushes the result.
// One sample in flight; every output is a register, so read/write have no combinational input path.
module audio_stream_ctrl #(
   parameter int DATA_W       = 24,
   parameter int PROC_TIMEOUT = 1024,
   parameter int CNT_W        = 16
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              read_ready,
   input  logic              write_ready,
   input  logic [DATA_W-1:0] readdata_left,
   input  logic [DATA_W-1:0] readdata_right,
   output logic              read,
   output logic              write,
   output logic [DATA_W-1:0] writedata_left,
   output logic [DATA_W-1:0] writedata_right,
   output logic              proc_start,
   output logic [DATA_W-1:0] proc_in_left,
   output logic [DATA_W-1:0] proc_in_right,
   input  logic              proc_done,
   input  logic [DATA_W-1:0] proc_out_left,
   input  logic [DATA_W-1:0] proc_out_right,
   input  logic              bypass,
   input  logic              mute,
   output logic              busy,
   output logic [CNT_W-1:0]  sample_count,
   output logic [7:0]        timeout_count
);
   localparam int TW = $clog2(PROC_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, POP, PROC, WAIT_WR, WRITE} state_t;
   state_t        r_state;
   logic          r_mute;
   logic [TW-1:0] r_timer;
   logic          w_done;
   logic          w_expire;
   // done arriving alongside proc_start belongs to a previous request, so it is ignored
   assign w_done   = proc_done && r_timer != '0;
   assign w_expire = r_timer == TW'(PROC_TIMEOUT - 1);
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state         <= IDLE;
         r_mute          <= 1'b0;
         r_timer         <= '0;
         read            <= 1'b0;
         write           <= 1'b0;
         proc_start      <= 1'b0;
         busy            <= 1'b0;
         writedata_left  <= '0;
         writedata_right <= '0;
         proc_in_left    <= '0;
         proc_in_right   <= '0;
         sample_count    <= '0;
         timeout_count   <= '0;
      end else begin
         read       <= 1'b0;
         write      <= 1'b0;
         proc_start <= 1'b0;
         case (r_state)
            IDLE: if (read_ready) begin
               proc_in_left  <= readdata_left;
               proc_in_right <= readdata_right;
               read          <= 1'b1;
               busy          <= 1'b1;
               r_state       <= POP;
            end
            POP: begin
               r_mute <= mute;
               if (bypass) begin
                  writedata_left  <= mute ? '0 : proc_in_left;
                  writedata_right <= mute ? '0 : proc_in_right;
                  r_state         <= WAIT_WR;
               end else begin
                  proc_start <= 1'b1;
                  r_timer    <= '0;
                  r_state    <= PROC;
               end
            end
            PROC: begin
               r_timer <= r_timer + TW'(1);
               if (w_done) begin
                  writedata_left  <= r_mute ? '0 : proc_out_left;
                  writedata_right <= r_mute ? '0 : proc_out_right;
                  r_state         <= WAIT_WR;
               end else if (w_expire) begin
                  writedata_left  <= r_mute ? '0 : proc_in_left;
                  writedata_right <= r_mute ? '0 : proc_in_right;
                  timeout_count   <= timeout_count == 8'hFF ? timeout_count : timeout_count + 8'd1;
                  r_state         <= WAIT_WR;
               end
            end
            WAIT_WR: if (write_ready) begin
               write        <= 1'b1;
               sample_count <= sample_count + CNT_W'(1);
               r_state      <= WRITE;
            end
            WRITE: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
